vx_writeback_arbiter: RTL and testbench
=======================================

Name: vx_writeback_arbiter

Overview:
- Writeback stage feeding the context/register-file write port (write enable, rd, warp, thread mask, per-thread data).
- Merges two result sources: execute (ALU/CSR/JAL link, cannot stall) and memory response (can be back-pressured).
- Produces at most one registered write per cycle. Execute always has priority; memory results wait in a small FIFO.

Parameters:
- NT, 4, threads per warp; width of thread mask and number of 32-bit data lanes.
- MEM_Q_DEPTH, 4, memory-result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_ex_write  in  1  execute result requests a register write this cycle
- in_ex_rd  in  5  execute destination register
- in_ex_warp  in  1  execute warp id
- in_ex_valid  in  NT  execute thread mask
- in_ex_data  in  NT*32  execute data; lane i is bits [32i+31:32i]
- in_mem_valid  in  1  memory response present
- in_mem_rd  in  5  memory destination register
- in_mem_warp  in  1  memory warp id
- in_mem_mask  in  NT  memory thread mask
- in_mem_data  in  NT*32  memory load data
- out_mem_ready  out  1  FIFO can accept a response this cycle
- out_write_register  out  1  write strobe to register file
- out_rd  out  5  destination register
- out_wb_warp  out  1  warp id
- out_valid  out  NT  per-thread write mask
- out_write_data  out  NT*32  per-thread write data
- out_mem_pending  out  $clog2(MEM_Q_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs except out_mem_ready go to 0; FIFO pointers and count go to 0.
  - out_mem_ready is 1 after reset is released; it is 0 while reset is asserted.
  - Reset mid-operation discards all queued entries, with no partial write.
- Execute request is effective when in_ex_write=1, in_ex_rd!=0 and in_ex_valid!=0.
  - An effective request accepted in cycle N drives the registered outputs in cycle N+1.
  - Execute is never stalled.
- Memory push:
  - Push occurs when in_mem_valid && out_mem_ready.
  - A response with in_mem_rd==0 or in_mem_mask==0 is accepted (handshake completes) but not enqueued.
- out_mem_ready = (count < MEM_Q_DEPTH), combinational from the count register only.
  - A response presented while ready=0 is a protocol violation; it is ignored and count is unchanged.
- Pop: when there is no effective execute request in cycle N and the FIFO is non-empty, the head is popped and registered, driving the outputs in N+1.
- Output register selection each cycle, in priority order: effective execute request, then FIFO head, then idle.
  - Idle: out_write_register=0 and out_valid=0.
  - On idle, out_rd, out_wb_warp and out_write_data hold their previous values.
- Simultaneous push and pop in the same cycle: count is unchanged and pointers advance independently.
  - A push while full is impossible because ready is low.
- Pointer and count arithmetic:
  - Pointers are $clog2(MEM_Q_DEPTH) bits and wrap modulo depth.
  - count is a separate register, 0..MEM_Q_DEPTH.
- Ordering:
  - Memory results retire in arrival order.
  - Execute and memory results may reorder relative to each other; hazard tracking upstream is responsible for that.
- Latency without bypass:
  - Memory response pushed in N, with no execute traffic: earliest write output in N+2.
  - Each cycle with an effective execute request delays the FIFO head by one cycle.

Optional Feature:
- Macro: VX_WB_MEM_BYPASS_EN.
- Defined: when the FIFO is empty and there is no effective execute request in cycle N, a valid memory response skips the FIFO and is registered directly, so the write appears in N+1.
  - Count stays 0 and out_mem_ready stays 1.
  - If execute is active in that cycle, the response is enqueued as normal.
- Undefined: every memory response goes through the FIFO, with minimum latency 2.

Test Plan:
- Reset then idle → out_write_register=0, out_valid=0, out_mem_ready=1, out_mem_pending=0. Assert reset mid-stream with 3 entries queued → pending=0 immediately, no write strobe after release.
- Execute write rd=5, warp=1, mask=4'b1011, lane data 0x11,0x22,0x33,0x44 in cycle 10 → cycle 11 shows strobe=1, rd=5, warp=1, valid=1011, matching data. Repeat with rd=0 → no strobe.
- Memory response rd=7 data 0xDEADBEEF (all lanes) in cycle 20 with execute idle → strobe with rd=7 in cycle 22, or cycle 21 with VX_WB_MEM_BYPASS_EN.
- Execute write on every cycle 30..35 while memory pushes rd=8,9,10,11,12 → pending reaches 4, ready=0 at count 4, rd=12 held off; drains rd=8,9,10,11 in order in cycles 37..40, then rd=12 follows once ready.
- Memory push while popping with count=2 → count stays 2; push rd=0 → handshake completes, pending unchanged, no write produced.
- Wrap: push and pop 10 responses, rd=1..10, at depth 4 → written in order 1..10, pending back to 0, no loss or duplication.

Source files
------------

// File: rtl/vx_writeback_arbiter.sv
// Writeback arbiter: merges non-stallable execute results with back-pressured
// memory responses into one registered register-file write per cycle.
// Optional macro VX_WB_MEM_BYPASS_EN lets a memory response skip an empty FIFO.
module vx_writeback_arbiter #(
  parameter int unsigned NT          = 4,
  parameter int unsigned MEM_Q_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_ex_write,
  input  logic [4:0]                     in_ex_rd,
  input  logic                           in_ex_warp,
  input  logic [NT-1:0]                  in_ex_valid,
  input  logic [NT*32-1:0]               in_ex_data,
  input  logic                           in_mem_valid,
  input  logic [4:0]                     in_mem_rd,
  input  logic                           in_mem_warp,
  input  logic [NT-1:0]                  in_mem_mask,
  input  logic [NT*32-1:0]               in_mem_data,
  output logic                           out_mem_ready,
  output logic                           out_write_register,
  output logic [4:0]                     out_rd,
  output logic                           out_wb_warp,
  output logic [NT-1:0]                  out_valid,
  output logic [NT*32-1:0]               out_write_data,
  output logic [$clog2(MEM_Q_DEPTH):0]   out_mem_pending
);

  localparam int unsigned PTR_W  = $clog2(MEM_Q_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = NT * 32;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [4:0]        q_rd   [MEM_Q_DEPTH];
  logic              q_warp [MEM_Q_DEPTH];
  logic [NT-1:0]     q_mask [MEM_Q_DEPTH];
  logic [DATA_W-1:0] q_data [MEM_Q_DEPTH];

  logic ex_eff;
  logic mem_eff;
  logic mem_hs;
  logic bypass;
  logic push;
  logic pop;

  // Ready depends only on occupancy; held low while reset is asserted.
  assign out_mem_ready   = !reset && (count < CNT_W'(MEM_Q_DEPTH));
  assign out_mem_pending = count;

  assign ex_eff  = in_ex_write && (in_ex_rd != 5'd0) && (in_ex_valid != '0);
  assign mem_eff = (in_mem_rd != 5'd0) && (in_mem_mask != '0);
  assign mem_hs  = in_mem_valid && out_mem_ready;

`ifdef VX_WB_MEM_BYPASS_EN
  assign bypass = mem_hs && mem_eff && !ex_eff && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Null responses (rd 0 or empty mask) complete the handshake but are dropped.
  assign push = mem_hs && mem_eff && !bypass;
  assign pop  = !ex_eff && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= in_mem_rd;
      q_warp[wr_ptr] <= in_mem_warp;
      q_mask[wr_ptr] <= in_mem_mask;
      q_data[wr_ptr] <= in_mem_data;
    end
  end

  // Output register: execute, then FIFO head, then bypass, else idle with held payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_write_register <= 1'b0;
      out_rd             <= '0;
      out_wb_warp        <= 1'b0;
      out_valid          <= '0;
      out_write_data     <= '0;
    end else if (ex_eff) begin
      out_write_register <= 1'b1;
      out_rd             <= in_ex_rd;
      out_wb_warp        <= in_ex_warp;
      out_valid          <= in_ex_valid;
      out_write_data     <= in_ex_data;
    end else if (pop) begin
      out_write_register <= 1'b1;
      out_rd             <= q_rd[rd_ptr];
      out_wb_warp        <= q_warp[rd_ptr];
      out_valid          <= q_mask[rd_ptr];
      out_write_data     <= q_data[rd_ptr];
    end else if (bypass) begin
      out_write_register <= 1'b1;
      out_rd             <= in_mem_rd;
      out_wb_warp        <= in_mem_warp;
      out_valid          <= in_mem_mask;
      out_write_data     <= in_mem_data;
    end else begin
      out_write_register <= 1'b0;
      out_valid          <= '0;
    end
  end

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Scoreboard bench for vx_writeback_arbiter (NT=4, MEM_Q_DEPTH=4).
module tb_vx_writeback_arbiter;

  localparam int unsigned NT = 4;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_ex_write;
  logic [4:0]     in_ex_rd;
  logic           in_ex_warp;
  logic [NT-1:0]  in_ex_valid;
  logic [127:0]   in_ex_data;
  logic           in_mem_valid;
  logic [4:0]     in_mem_rd;
  logic           in_mem_warp;
  logic [NT-1:0]  in_mem_mask;
  logic [127:0]   in_mem_data;
  logic           out_mem_ready;
  logic           out_write_register;
  logic [4:0]     out_rd;
  logic           out_wb_warp;
  logic [NT-1:0]  out_valid;
  logic [127:0]   out_write_data;
  logic [2:0]     out_mem_pending;

  typedef struct {
    logic [4:0]    rd;
    logic          warp;
    logic [3:0]    mask;
    logic [127:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

`ifdef VX_WB_MEM_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  vx_writeback_arbiter #(.NT(NT), .MEM_Q_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_ex_write(in_ex_write), .in_ex_rd(in_ex_rd), .in_ex_warp(in_ex_warp),
    .in_ex_valid(in_ex_valid), .in_ex_data(in_ex_data),
    .in_mem_valid(in_mem_valid), .in_mem_rd(in_mem_rd), .in_mem_warp(in_mem_warp),
    .in_mem_mask(in_mem_mask), .in_mem_data(in_mem_data),
    .out_mem_ready(out_mem_ready), .out_write_register(out_write_register),
    .out_rd(out_rd), .out_wb_warp(out_wb_warp), .out_valid(out_valid),
    .out_write_data(out_write_data), .out_mem_pending(out_mem_pending)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the scoreboard head; idle must have no mask.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (out_write_register) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got rd=%0d warp=%0d mask=%b, required no write",
                   out_rd, out_wb_warp, out_valid);
        end else begin
          mon_e = sb.pop_front();
          if (out_rd !== mon_e.rd || out_wb_warp !== mon_e.warp ||
              out_valid !== mon_e.mask || out_write_data !== mon_e.data) begin
            errors++;
            $display("FAIL wb_payload got rd=%0d warp=%0d mask=%b data=%h, required rd=%0d warp=%0d mask=%b data=%h",
                     out_rd, out_wb_warp, out_valid, out_write_data,
                     mon_e.rd, mon_e.warp, mon_e.mask, mon_e.data);
          end
        end
      end else if (out_valid !== 4'b0) begin
        errors++;
        $display("FAIL idle_mask got %b, required 0000", out_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic warp, input logic [3:0] mask,
                          input logic [127:0] data);
    in_ex_write = 1'b1; in_ex_rd = rd; in_ex_warp = warp;
    in_ex_valid = mask; in_ex_data = data;
  endtask

  task automatic idle_ex();
    in_ex_write = 1'b0; in_ex_rd = 5'd0; in_ex_warp = 1'b0;
    in_ex_valid = 4'b0; in_ex_data = '0;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic warp, input logic [3:0] mask,
                           input logic [127:0] data);
    in_mem_valid = 1'b1; in_mem_rd = rd; in_mem_warp = warp;
    in_mem_mask = mask; in_mem_data = data;
  endtask

  task automatic idle_mem();
    in_mem_valid = 1'b0; in_mem_rd = 5'd0; in_mem_warp = 1'b0;
    in_mem_mask = 4'b0; in_mem_data = '0;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic warp, input logic [3:0] mask,
                           input logic [127:0] data);
    exp_t e;
    e.rd = rd; e.warp = warp; e.mask = mask; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    reset = 1'b1;
    idle_ex();
    idle_mem();
    #12;
    chk("ready_in_reset", 32'(out_mem_ready), 32'd0);
    chk("pending_in_reset", 32'(out_mem_pending), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_strobe", 32'(out_write_register), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(out_mem_ready), 32'd1);
    chk("reset_pending", 32'(out_mem_pending), 32'd0);

    // Execute write with lane data 0x11..0x44, then rd=0 which must not write.
    drive_ex(5'd5, 1'b1, 4'b1011, {32'h44, 32'h33, 32'h22, 32'h11});
    expect_wr(5'd5, 1'b1, 4'b1011, {32'h44, 32'h33, 32'h22, 32'h11});
    tick();
    chk("ex_strobe_n1", 32'(out_write_register), 32'd1);
    drive_ex(5'd0, 1'b1, 4'b1111, {4{32'h55}});
    tick();
    chk("ex_rd0_no_strobe", 32'(out_write_register), 32'd0);
    idle_ex();
    tick();

    // Memory response latency with execute idle.
    drive_mem(5'd7, 1'b0, 4'hF, {4{32'hDEADBEEF}});
    expect_wr(5'd7, 1'b0, 4'hF, {4{32'hDEADBEEF}});
    tick();
    idle_mem();
    chk("mem_lat_n1", 32'(out_write_register), 32'(BYP));
    tick();
    chk("mem_lat_n2", 32'(out_write_register), 32'(!BYP));
    drain("drain_mem_lat", 5);

    // Execute every cycle while memory fills the FIFO; rd=12 is held off at full.
    for (int i = 0; i < 6; i++) begin
      drive_ex(5'(20 + i), i[0], 4'hF, {4{32'(100 + i)}});
      expect_wr(5'(20 + i), i[0], 4'hF, {4{32'(100 + i)}});
      if (i < 4) drive_mem(5'(8 + i), 1'b1, 4'b0101, {4{32'(200 + i)}});
      else drive_mem(5'd12, 1'b1, 4'b0101, {4{32'd212}});
      if (i >= 4) begin
        chk("full_pending", 32'(out_mem_pending), 32'd4);
        chk("full_ready", 32'(out_mem_ready), 32'd0);
      end
      tick();
    end
    idle_ex();
    for (int i = 0; i < 4; i++) expect_wr(5'(8 + i), 1'b1, 4'b0101, {4{32'(200 + i)}});
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      if (out_mem_ready) begin
        expect_wr(5'd12, 1'b1, 4'b0101, {4{32'd212}});
        done = 1'b1;
      end
      tick();
    end
    idle_mem();
    chk("rd12_accepted", 32'(done), 32'd1);
    drain("drain_full", 20);
    chk("full_pending_end", 32'(out_mem_pending), 32'd0);

    // Build count=2, null push while busy, then push during pop.
    drive_ex(5'd1, 1'b0, 4'h1, {4{32'hA1}}); expect_wr(5'd1, 1'b0, 4'h1, {4{32'hA1}});
    drive_mem(5'd1, 1'b0, 4'h3, {4{32'hB1}});
    tick();
    drive_ex(5'd2, 1'b0, 4'h2, {4{32'hA2}}); expect_wr(5'd2, 1'b0, 4'h2, {4{32'hA2}});
    drive_mem(5'd2, 1'b0, 4'h3, {4{32'hB2}});
    tick();
    chk("pend2", 32'(out_mem_pending), 32'd2);
    drive_ex(5'd3, 1'b0, 4'h4, {4{32'hA3}}); expect_wr(5'd3, 1'b0, 4'h4, {4{32'hA3}});
    drive_mem(5'd0, 1'b0, 4'hF, {4{32'hB0}});
    chk("null_ready", 32'(out_mem_ready), 32'd1);
    tick();
    chk("null_pending", 32'(out_mem_pending), 32'd2);
    expect_wr(5'd1, 1'b0, 4'h3, {4{32'hB1}});
    expect_wr(5'd2, 1'b0, 4'h3, {4{32'hB2}});
    expect_wr(5'd3, 1'b0, 4'h3, {4{32'hB3}});
    idle_ex();
    drive_mem(5'd3, 1'b0, 4'h3, {4{32'hB3}});
    tick();
    idle_mem();
    chk("pushpop_pending", 32'(out_mem_pending), 32'd2);
    drain("drain_pushpop", 10);
    chk("pushpop_pending_end", 32'(out_mem_pending), 32'd0);

    // Reset with 3 entries queued: they must never be written.
    for (int i = 0; i < 3; i++) begin
      drive_ex(5'(26 + i), 1'b1, 4'h8, {4{32'(300 + i)}});
      expect_wr(5'(26 + i), 1'b1, 4'h8, {4{32'(300 + i)}});
      drive_mem(5'(13 + i), 1'b1, 4'hF, {4{32'(400 + i)}});
      tick();
    end
    idle_ex();
    idle_mem();
    chk("pre_reset_pending", 32'(out_mem_pending), 32'd3);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_pending", 32'(out_mem_pending), 32'd0);
    chk("midreset_ready", 32'(out_mem_ready), 32'd0);
    chk("midreset_strobe", 32'(out_write_register), 32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("post_reset_sb", 32'(sb.size()), 32'd0);
    chk("post_reset_pending", 32'(out_mem_pending), 32'd0);
    chk("post_reset_ready", 32'(out_mem_ready), 32'd1);

    // Pointer wrap: ten responses back to back.
    for (int i = 1; i <= 10; i++) begin
      drive_mem(5'(i), i[0], 4'hF, {4{32'(500 + i)}});
      expect_wr(5'(i), i[0], 4'hF, {4{32'(500 + i)}});
      tick();
    end
    idle_mem();
    drain("drain_wrap", 20);
    chk("wrap_pending", 32'(out_mem_pending), 32'd0);

    tick(); tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
